// File: rtl/ahb_mem_bridge.sv
// AHB-Lite slave bridging one AHB port onto a memory request/response port.
// Writes are posted through a small FIFO; reads wait for the FIFO to drain
// so that memory always observes writes before a later read.
module ahb_mem_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_BYTES  = 4096,
  parameter int WBUF_DEPTH = 2
) (
  input  logic                    i_clk_ahb,
  input  logic                    i_rstn_ahb,
  input  logic                    i_hselx,
  input  logic                    i_hready,
  input  logic [1:0]              i_htrans,
  input  logic [2:0]              i_hsize,
  input  logic                    i_hwrite,
  input  logic [ADDR_WIDTH-1:0]   i_haddr,
  input  logic [DATA_WIDTH-1:0]   i_hwdata,
  output logic                    o_hreadyout,
  output logic                    o_hresp,
  output logic [DATA_WIDTH-1:0]   o_hrdata,
  output logic                    o_valid,
  output logic                    o_rd0_wr1,
  output logic [ADDR_WIDTH-1:0]   o_addr,
  output logic [DATA_WIDTH-1:0]   o_wr_data,
  output logic [DATA_WIDTH/8-1:0] o_wstrb,
  input  logic                    i_ready,
  input  logic                    i_rd_valid,
  input  logic [DATA_WIDTH-1:0]   i_rd_data
);
  localparam int B  = DATA_WIDTH / 8;
  localparam int LB = $clog2(B);
  localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CW = $clog2(WBUF_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_RREQ, S_RWAIT, S_RDONE, S_ERR1, S_ERR2
  } state_t;

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_size;
  logic [DATA_WIDTH-1:0] r_hrdata;
  logic [ADDR_WIDTH-1:0] r_fa [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] r_fd [WBUF_DEPTH];
  logic [B-1:0]          r_fs [WBUF_DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_count;

  logic w_sel_xfer, w_accept, w_hreadyout, w_bad;
  logic w_full, w_fifo_ne, w_push, w_pop, w_rd_req;

  // Out of range, misaligned for its size, or wider than the bus.
  function automatic logic f_bad(input logic [ADDR_WIDTH-1:0] a, input logic [2:0] sz);
    logic [ADDR_WIDTH-1:0] mask;
    mask = (ADDR_WIDTH'(1) << sz) - ADDR_WIDTH'(1);
    return (a >= ADDR_WIDTH'(MEM_BYTES)) || ((a & mask) != '0) || (sz > 3'(LB));
  endfunction

  // 2^sz consecutive lanes starting at the lane selected by the low address bits.
  function automatic logic [B-1:0] f_strb(input logic [LB-1:0] lane, input logic [2:0] sz);
    logic [B-1:0] s;
    int           n;
    n = 1 << sz;
    for (int i = 0; i < B; i++) s[i] = (i >= int'(lane)) && (i < int'(lane) + n);
    return s;
  endfunction

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(WBUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_sel_xfer = i_hselx && i_hready && ((i_htrans == 2'b10) || (i_htrans == 2'b11));
  assign w_bad      = f_bad(i_haddr, i_hsize);
  assign w_fifo_ne  = (r_count != '0);
  assign w_full     = (r_count == CW'(WBUF_DEPTH));
  assign w_push     = (r_state == S_WDATA) && !w_full;
  assign w_pop      = w_fifo_ne && i_ready;
  assign w_rd_req   = (r_state == S_RREQ) && !w_fifo_ne;

  // Next state and handshake outputs; hreadyout is a function of registered state only.
  always_comb begin
    w_next      = r_state;
    w_hreadyout = 1'b1;
    w_accept    = 1'b0;
    case (r_state)
      S_WDATA: w_hreadyout = !w_full;
      S_RREQ: begin
        w_hreadyout = 1'b0;
        if (w_rd_req && i_ready) w_next = S_RWAIT;
      end
      S_RWAIT: begin
        w_hreadyout = 1'b0;
        if (i_rd_valid) w_next = S_RDONE;
      end
      S_ERR1: begin
        w_hreadyout = 1'b0;
        w_next      = S_ERR2;
      end
      default: w_hreadyout = 1'b1;
    endcase
    if (w_hreadyout) begin
      w_accept = w_sel_xfer;
      if (w_sel_xfer) w_next = w_bad ? S_ERR1 : (i_hwrite ? S_WDATA : S_RREQ);
      else            w_next = S_IDLE;
    end
  end

  // Control state: FSM, FIFO pointers/count and captured read data.
  always_ff @(posedge i_clk_ahb) begin
    if (!i_rstn_ahb) begin
      r_state  <= S_IDLE;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_hrdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_push) r_wptr <= f_inc(r_wptr);
      if (w_pop)  r_rptr <= f_inc(r_rptr);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      if ((r_state == S_RWAIT) && i_rd_valid) r_hrdata <= i_rd_data;
    end
  end

  // Address-phase capture and FIFO storage; contents are qualified by state/count.
  always_ff @(posedge i_clk_ahb) begin
    if (w_accept) begin
      r_addr <= i_haddr;
      r_size <= i_hsize;
    end
    if (w_push) begin
      r_fa[r_wptr] <= r_addr;
      r_fd[r_wptr] <= i_hwdata;
      r_fs[r_wptr] <= f_strb(r_addr[LB-1:0], r_size);
    end
  end

  assign o_hreadyout = w_hreadyout;
  assign o_hresp     = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign o_hrdata    = r_hrdata;
  assign o_valid     = w_fifo_ne || w_rd_req;
  assign o_rd0_wr1   = w_fifo_ne;
  assign o_addr      = w_fifo_ne ? r_fa[r_rptr] : (w_rd_req ? r_addr : '0);
  assign o_wr_data   = w_fifo_ne ? r_fd[r_rptr] : '0;
  assign o_wstrb     = w_fifo_ne ? r_fs[r_rptr] : (w_rd_req ? '1 : '0);
endmodule
